// File: rtl/detector_test_sequencer_if.sv
`default_nettype none
// =============================================================================
// detector_test_sequencer_if : board-side and detector-side signals of the
// 101101 detector test sequencer. Macro SEQ_HIT_LOG_EN adds the hit-log signals.
// Revision: 1.0
// =============================================================================
interface detector_test_sequencer_if #(
  parameter int LEN   = 16,
  parameter int CNT_W = 4,
  parameter int IDX_W = 6
);
  logic             start;
  logic [LEN-1:0]   pattern;
  logic             mode;
  logic             z_in;
  logic             x_out;
  logic             m_out;
  logic             det_clr;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] hit_count;

`ifdef SEQ_HIT_LOG_EN
  logic [IDX_W-1:0] first_hit_idx;
  logic [IDX_W-1:0] last_hit_idx;
  logic             hit_seen;

  modport master (
    output start, pattern, mode, z_in,
    input  x_out, m_out, det_clr, busy, done, bit_idx, hit_count,
    input  first_hit_idx, last_hit_idx, hit_seen
  );
  modport slave (
    input  start, pattern, mode, z_in,
    output x_out, m_out, det_clr, busy, done, bit_idx, hit_count,
    output first_hit_idx, last_hit_idx, hit_seen
  );
`else
  modport master (
    output start, pattern, mode, z_in,
    input  x_out, m_out, det_clr, busy, done, bit_idx, hit_count
  );
  modport slave (
    input  start, pattern, mode, z_in,
    output x_out, m_out, det_clr, busy, done, bit_idx, hit_count
  );
`endif
endinterface
`default_nettype wire

// File: rtl/detector_test_sequencer.sv
`default_nettype none
// =============================================================================
// detector_test_sequencer : clears the detector, shifts a pattern MSB first into
// X, counts Z hits with Moore/Mealy timing compensation. Macro: SEQ_HIT_LOG_EN.
// Revision: 1.0
// =============================================================================
module detector_test_sequencer #(
  parameter int LEN   = 16,
  parameter int CNT_W = 4,
  parameter int IDX_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  detector_test_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic [LEN-1:0]   pat_sr, pat_sr_n;
  logic             x_n, m_n, det_clr_n, busy_n, done_n;
  logic [IDX_W-1:0] idx_n;
  logic [CNT_W-1:0] cnt_n;
  logic             accept, count_en, hit;

  // Moore Z lags its completing bit by one cycle: skip SHIFT 0, include DRAIN.
  assign accept   = (state == S_IDLE) && bus.start;
  assign count_en = ((state == S_SHIFT) && (bus.m_out || (bus.bit_idx != '0))) ||
                    ((state == S_DRAIN) && !bus.m_out);
  assign hit      = count_en && bus.z_in;

  always_comb begin
    state_n   = state;
    pat_sr_n  = pat_sr;
    x_n       = 1'b0;
    m_n       = bus.m_out;
    det_clr_n = 1'b0;
    busy_n    = 1'b1;
    done_n    = 1'b0;
    idx_n     = bus.bit_idx;
    cnt_n     = bus.hit_count;

    if (hit && (bus.hit_count != CNT_MAX)) begin
      cnt_n = bus.hit_count + 1'b1;
    end

    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (bus.start) begin
          state_n   = S_CLEAR;
          pat_sr_n  = bus.pattern;
          m_n       = bus.mode;
          cnt_n     = '0;
          idx_n     = '0;
          det_clr_n = 1'b1;
          busy_n    = 1'b1;
        end
      end
      S_CLEAR: begin
        state_n  = S_SHIFT;
        idx_n    = '0;
        x_n      = pat_sr[LEN-1];
        pat_sr_n = pat_sr << 1;
      end
      S_SHIFT: begin
        if (bus.bit_idx == LAST_IDX) begin
          state_n = S_DRAIN;
        end else begin
          idx_n    = bus.bit_idx + 1'b1;
          x_n      = pat_sr[LEN-1];
          pat_sr_n = pat_sr << 1;
        end
      end
      S_DRAIN: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      pat_sr        <= '0;
      bus.x_out     <= 1'b0;
      bus.m_out     <= 1'b0;
      bus.det_clr   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.bit_idx   <= '0;
      bus.hit_count <= '0;
    end else begin
      state         <= state_n;
      pat_sr        <= pat_sr_n;
      bus.x_out     <= x_n;
      bus.m_out     <= m_n;
      bus.det_clr   <= det_clr_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
      bus.bit_idx   <= idx_n;
      bus.hit_count <= cnt_n;
    end
  end

`ifdef SEQ_HIT_LOG_EN
  logic [IDX_W-1:0] log_idx, first_n, last_n;
  logic             seen_n;

  // Logged index is the completing bit, which for Moore is the previous one.
  assign log_idx = (bus.m_out || (state == S_DRAIN)) ? bus.bit_idx : (bus.bit_idx - 1'b1);

  always_comb begin
    first_n = bus.first_hit_idx;
    last_n  = bus.last_hit_idx;
    seen_n  = bus.hit_seen;
    if (accept) begin
      first_n = '0;
      last_n  = '0;
      seen_n  = 1'b0;
    end else if (hit) begin
      last_n = log_idx;
      if (!bus.hit_seen) begin
        first_n = log_idx;
        seen_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.first_hit_idx <= '0;
      bus.last_hit_idx  <= '0;
      bus.hit_seen      <= 1'b0;
    end else begin
      bus.first_hit_idx <= first_n;
      bus.last_hit_idx  <= last_n;
      bus.hit_seen      <= seen_n;
    end
  end
`endif

endmodule
`default_nettype wire
